// File: rtl/mac_seq_pkg.sv
// Shared types, default width and width helper for the MAC layer sequencer.
package mac_seq_pkg;

  localparam int unsigned DEF_DW = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ACCUM   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mac_addr_gen.sv
// Input, weight and neuron address counters for the MAC layer sequencer.
module mac_addr_gen #(
  parameter int unsigned IN_AW  = 2,
  parameter int unsigned W_AW   = 4,
  parameter int unsigned NEUR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_all,
  input  logic              clr_in,
  input  logic              inc_io,
  input  logic              inc_neur,
  output logic [IN_AW-1:0]  in_addr,
  output logic [W_AW-1:0]   w_addr,
  output logic [NEUR_W-1:0] neuron_idx
);

  logic [IN_AW-1:0]  in_addr_q, in_addr_d;
  logic [W_AW-1:0]   w_addr_q, w_addr_d;
  logic [NEUR_W-1:0] neur_q, neur_d;

  // w_addr runs across neurons; only in_addr restarts per neuron.
  always_comb begin
    in_addr_d = in_addr_q;
    w_addr_d  = w_addr_q;
    neur_d    = neur_q;
    if (clr_all) begin
      in_addr_d = '0;
      w_addr_d  = '0;
      neur_d    = '0;
    end else begin
      if (clr_in) begin
        in_addr_d = '0;
      end else if (inc_io) begin
        in_addr_d = in_addr_q + IN_AW'(1);
      end
      if (inc_io) begin
        w_addr_d = w_addr_q + W_AW'(1);
      end
      if (inc_neur) begin
        neur_d = neur_q + NEUR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_addr_q <= '0;
      w_addr_q  <= '0;
      neur_q    <= '0;
    end else begin
      in_addr_q <= in_addr_d;
      w_addr_q  <= w_addr_d;
      neur_q    <= neur_d;
    end
  end

  assign in_addr    = in_addr_q;
  assign w_addr     = w_addr_q;
  assign neuron_idx = neur_q;

endmodule

// File: rtl/mac_layer_sequencer.sv
// Sequences a shared MAC through a fully-connected layer, one neuron at a time.
module mac_layer_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_NEUR = 3,
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned IN_AW  = addr_w(N_IN),
  parameter int unsigned W_AW   = addr_w(N_IN * N_NEUR),
  parameter int unsigned NEUR_W = addr_w(N_NEUR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rst_Acc,
  output logic              ld_Acc,
  output logic [IN_AW-1:0]  in_addr,
  output logic [W_AW-1:0]   w_addr,
  output logic [NEUR_W-1:0] neuron_idx,
  input  logic [DW-1:0]     mac_result,
  output logic              out_we,
  output logic [NEUR_W-1:0] out_addr,
  output logic [DW-1:0]     out_data
);

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   rst_acc_q, rst_acc_d;
  logic   ld_acc_q, ld_acc_d;
  logic   clr_all, clr_in, inc_io, inc_neur;

  // Next state and next registered outputs; abort overrides any non-idle transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = ACCUM;
      ACCUM:   if (in_addr == IN_AW'(N_IN - 1)) state_d = CAPTURE;
      CAPTURE: state_d = (neuron_idx == NEUR_W'(N_NEUR - 1)) ? DONE : CLEAR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    rst_acc_d = (state_d == IDLE) || (state_d == CLEAR) || (state_d == DONE);
    ld_acc_d  = (state_d == ACCUM);

    clr_all  = (state_d == IDLE);
    clr_in   = (state_d == CLEAR);
    inc_io   = (state_q == ACCUM);
    inc_neur = (state_q == CAPTURE) && (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rst_acc_q <= 1'b1;
      ld_acc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rst_acc_q <= rst_acc_d;
      ld_acc_q  <= ld_acc_d;
    end
  end

  mac_addr_gen #(
    .IN_AW  (IN_AW),
    .W_AW   (W_AW),
    .NEUR_W (NEUR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clr_all    (clr_all),
    .clr_in     (clr_in),
    .inc_io     (inc_io),
    .inc_neur   (inc_neur),
    .in_addr    (in_addr),
    .w_addr     (w_addr),
    .neuron_idx (neuron_idx)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign rst_Acc = rst_acc_q;
  assign ld_Acc  = ld_acc_q;

  // The accumulator only settles in CAPTURE, so the write port passes the MAC result straight through.
  assign out_we   = (state_q == CAPTURE) && !abort && !rst;
  assign out_addr = neuron_idx;
  assign out_data = mac_result;

endmodule
